// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush/hold sequencing for the IF-ID-EX-MEM-WB pipeline.
// Define HAZARD_FORWARD_EN for EX operand forwarding; the default build interlocks only.
module hazard_ctrl #(
  parameter int REG_AW     = 2,
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic              ex_hold,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  typedef enum logic [1:0] {
    OP_LDA = 2'b00,
    OP_STA = 2'b01,
    OP_IMM = 2'b10,
    OP_BAF = 2'b11
  } op_class_e;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  op_class_e id_class;
  logic      id_writes;
  logic      id_rs2_used;
  logic      id_is_mul;
  logic      id_advance;
  logic      hazard;

  // Shadow slots: EX carries enough to forward, MEM/WB only the write target.
  logic              ex_v_q,   ex_v_d;
  logic [REG_AW-1:0] ex_rd_q,  ex_rd_d;
  logic              ex_wr_q,  ex_wr_d;
  logic              mem_v_q,  mem_v_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              wb_v_q,   wb_v_d;
  logic [REG_AW-1:0] wb_rd_q,  wb_rd_d;
  logic              wb_wr_q,  wb_wr_d;
  logic [3:0]        mul_cnt_q, mul_cnt_d;

`ifdef HAZARD_FORWARD_EN
  logic              id_is_load;
  logic              ex_load_q, ex_load_d;
  logic [REG_AW-1:0] ex_rs1_q,  ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q,  ex_rs2_d;
  logic              ex_rs2u_q, ex_rs2u_d;
`endif

  function automatic logic rd_hit(
    input logic              v,
    input logic              wr,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs1,
    input logic [REG_AW-1:0] rs2,
    input logic              use2
  );
    return v && wr && ((rd == rs1) || (use2 && (rd == rs2)));
  endfunction

`ifdef HAZARD_FORWARD_EN
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              src_used,
    input logic              m_v,
    input logic              m_wr,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_v,
    input logic              w_wr,
    input logic [REG_AW-1:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src_used) begin
      if (m_v && m_wr && (m_rd == src)) begin
        sel = 2'b01;
      end else if (w_v && w_wr && (w_rd == src)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction
`endif

  always_comb begin
    id_class    = op_class_e'(id_opcode[3:2]);
    id_writes   = (id_class == OP_LDA) || (id_class == OP_IMM);
    id_rs2_used = (id_class == OP_STA);
    id_is_mul   = (id_class == OP_IMM) && (id_opcode[1:0] == 2'b10);
`ifdef HAZARD_FORWARD_EN
    id_is_load  = (id_class == OP_LDA);
`endif
  end

  // With forwarding only a load still in EX cannot supply its result in time.
`ifdef HAZARD_FORWARD_EN
  assign hazard = id_valid &&
                  rd_hit(ex_v_q, ex_load_q, ex_rd_q, id_rs1, id_rs2, id_rs2_used);
  assign fwd_a  = fwd_sel(ex_rs1_q, ex_v_q, mem_v_q, mem_wr_q, mem_rd_q,
                          wb_v_q, wb_wr_q, wb_rd_q);
  assign fwd_b  = fwd_sel(ex_rs2_q, ex_v_q && ex_rs2u_q, mem_v_q, mem_wr_q, mem_rd_q,
                          wb_v_q, wb_wr_q, wb_rd_q);
`else
  assign hazard = id_valid &&
                  (rd_hit(ex_v_q,  ex_wr_q,  ex_rd_q,  id_rs1, id_rs2, id_rs2_used) ||
                   rd_hit(mem_v_q, mem_wr_q, mem_rd_q, id_rs1, id_rs2, id_rs2_used) ||
                   rd_hit(wb_v_q,  wb_wr_q,  wb_rd_q,  id_rs1, id_rs2, id_rs2_used));
  assign fwd_a  = 2'b00;
  assign fwd_b  = 2'b00;
`endif

  always_comb begin
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    ex_hold = 1'b0;
    if (mul_cnt_q != 4'd0) begin
      ex_hold = 1'b1;
      stall   = 1'b1;
    end else if (ex_branch_taken) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (hazard) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

  assign id_advance = id_valid && !bubble;

  always_comb begin
    ex_v_d   = ex_v_q;
    ex_rd_d  = ex_rd_q;
    ex_wr_d  = ex_wr_q;
    mem_v_d  = ex_v_q;
    mem_rd_d = ex_rd_q;
    mem_wr_d = ex_wr_q;
    wb_v_d   = mem_v_q;
    wb_rd_d  = mem_rd_q;
    wb_wr_d  = mem_wr_q;
`ifdef HAZARD_FORWARD_EN
    ex_load_d = ex_load_q;
    ex_rs1_d  = ex_rs1_q;
    ex_rs2_d  = ex_rs2_q;
    ex_rs2u_d = ex_rs2u_q;
`endif
    mul_cnt_d = (mul_cnt_q != 4'd0) ? (mul_cnt_q - 4'd1) : 4'd0;

    if (ex_hold) begin
      mem_v_d  = 1'b0;
      mem_wr_d = 1'b0;
    end else begin
      ex_v_d  = id_advance;
      ex_rd_d = id_advance ? id_rd : '0;
      ex_wr_d = id_advance && id_writes;
`ifdef HAZARD_FORWARD_EN
      ex_load_d = id_advance && id_is_load;
      ex_rs1_d  = id_advance ? id_rs1 : '0;
      ex_rs2_d  = id_advance ? id_rs2 : '0;
      ex_rs2u_d = id_advance && id_rs2_used;
`endif
      if (id_advance && id_is_mul) begin
        mul_cnt_d = MUL_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_v_q    <= 1'b0;
      ex_rd_q   <= '0;
      ex_wr_q   <= 1'b0;
      mem_v_q   <= 1'b0;
      mem_rd_q  <= '0;
      mem_wr_q  <= 1'b0;
      wb_v_q    <= 1'b0;
      wb_rd_q   <= '0;
      wb_wr_q   <= 1'b0;
      mul_cnt_q <= 4'd0;
`ifdef HAZARD_FORWARD_EN
      ex_load_q <= 1'b0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      ex_rs2u_q <= 1'b0;
`endif
    end else begin
      ex_v_q    <= ex_v_d;
      ex_rd_q   <= ex_rd_d;
      ex_wr_q   <= ex_wr_d;
      mem_v_q   <= mem_v_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      wb_v_q    <= wb_v_d;
      wb_rd_q   <= wb_rd_d;
      wb_wr_q   <= wb_wr_d;
      mul_cnt_q <= mul_cnt_d;
`ifdef HAZARD_FORWARD_EN
      ex_load_q <= ex_load_d;
      ex_rs1_q  <= ex_rs1_d;
      ex_rs2_q  <= ex_rs2_d;
      ex_rs2u_q <= ex_rs2u_d;
`endif
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 4-stage-after-fetch CPU (IF, ID, EX, MEM, WB). It sits beside the opcode decoder and consumes the instruction in ID. It keeps a shadow record of the destination registers in EX, MEM and WB, and issues the stall, bubble, flush and hold controls that sequence the pipeline registers. It also times multi-cycle multiplies in EX and, optionally, drives the EX operand forwarding muxes.

## Interface
Parameters:
- REG_AW, 2: register-index width.
- MUL_CYCLES, 3: EX occupancy of a multiply, legal range 1..15.

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID/IF-ID register holds a real instruction.
- id_opcode  in  4  opcode of the ID instruction.
- id_rd  in  REG_AW  destination index.
- id_rs1  in  REG_AW  source 1 index.
- id_rs2  in  REG_AW  source 2 index.
- ex_branch_taken  in  1  branch in EX resolved taken (src1-imm==0).
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load NOP into ID/EX.
- flush  out  1  kill IF/ID contents.
- ex_hold  out  1  hold ID/EX (EX busy); MEM receives a NOP.
- fwd_a  out  2  EX operand-1 source: 00 regfile, 01 MEM result, 10 WB result.
- fwd_b  out  2  EX operand-2 source, same encoding.

## Operation
Internal decode of id_opcode[3:2]:
- LDA=00: reads rs1, writes rd, is a load.
- STA=01: reads rs1 and rs2, no write.
- IMM=10: reads rs1, writes rd.
- BAF=11: reads rs1, no write, is a branch.
- A multiply is an IMM-class instruction with id_opcode[1:0]==2'b10.
- r0 is an ordinary register.

Shadow slots:
- EX slot: v, rd, wr, load, rs1, rs2, rs2_used.
- MEM slot and WB slot: v, rd, wr.
- Slots advance every cycle that ex_hold=0.
- EX loads the ID entry, or an invalid entry when bubble, flush or !id_valid.
- While ex_hold=1: EX holds, MEM loads invalid, WB loads from MEM.

RAW hazard: an ID source that is read matches the rd of a valid, writing slot.

Control, in priority order (combinational from shadow state and ID inputs):
1. ex_hold = (mul_cnt != 0). stall=1, bubble=0, flush=0.
2. ex_branch_taken = 1: flush=1, bubble=1, stall=0. The ID instruction is discarded; no hazard is evaluated.
3. Hazard (rules under Configuration): stall=1, bubble=1.
4. Otherwise all controls are 0.

Multiply counter (4 bits):
- Loads MUL_CYCLES-1 when a multiply advances from ID into EX.
- Otherwise decrements while nonzero.
- The multiply occupies EX for exactly MUL_CYCLES cycles. MUL_CYCLES=1 never asserts ex_hold.

## Timing
- All outputs are combinational in the same cycle; no latency from ID inputs.
- Reset (reset_n low at an edge): all slot v=0, mul_cnt=0. Resulting outputs: stall=bubble=flush=ex_hold=0, fwd_a=fwd_b=00.
- Reset asserted mid-multiply or mid-stall aborts it; the first cycle after reset release shows all outputs idle.
- A load-use stall lasts exactly 1 cycle with FORWARD_EN.
- Without FORWARD_EN, a stall lasts until the producer leaves WB: 3 cycles when the producer is in EX.
- A branch taken together with an ID hazard produces flush only, with no stall.
- A branch cannot be in EX while ex_hold=1.

## Configuration
Macro: HAZARD_FORWARD_EN.

Defined:
- A hazard exists only when the EX slot is a valid load whose rd matches a read ID source.
- fwd_a/fwd_b compare the EX slot rs1 and rs2 (rs2 only if used) against MEM first, then WB; each slot must be valid and writing. Otherwise 00.

Undefined:
- A hazard exists for any RAW match against the EX, MEM or WB slot; the register file has no write-through.
- fwd_a and fwd_b are tied to 00.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with id_valid=1 -> all outputs 0/00. Release with no hazards -> outputs stay 0.
- Load-use: LDA r1, then IMM reading r1. With FORWARD_EN -> stall=bubble=1 for 1 cycle, then fwd_a=01. Without it -> stall=bubble=1 for 3 cycles.
- Forward priority (FORWARD_EN): IMM r2, IMM r2, then IMM reading r2 -> fwd_a=01 (MEM beats WB). Insert one NOP between the second producer and the reader -> fwd_a=10.
- Branch: BAF in EX with ex_branch_taken=1 while ID holds a RAW-hazard instruction -> flush=1, bubble=1, stall=0. The next cycle shows EX slot invalid.
- Multiply: MUL_CYCLES=3, issue opcode 4'b1010 -> ex_hold=stall=1 for the 2 cycles after entry, with MEM invalid during them. A second multiply immediately after -> hold repeats for 2 cycles.
- Reset mid-multiply: reset_n=0 on the first ex_hold cycle -> ex_hold=0 after release.
